// File: rtl/alu_nibble_addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit: state encoding
// and the helpers that size the nibble index from the operand width.
package alu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int nib_count(input int width);
    return width / 4;
  endfunction

  function automatic int idx_width(input int width);
    return $clog2(nib_count(width));
  endfunction

  localparam int IDX_W = idx_width(32);

endpackage

// File: rtl/alu_nibble_addsub_if.sv
// Request/response bundle between the ALU operand registers and the add/sub unit.
// Handshake: start is taken on a rising edge only while busy is low; start while
// busy is dropped. done pulses for one cycle when result and flags become final.
interface alu_nibble_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry, overflow, zero
  );
endinterface

// File: rtl/alu_nibble_addsub_cla.sv
// 4-bit carry-lookahead nibble adder with group generate/propagate outputs.
// The group carry-out is formed by the caller as gout | (pout & cin).
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       gout,
  output logic       pout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c;
  assign gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pout = &p;
endmodule

// File: rtl/alu_nibble_addsub.sv
// Nibble-serial WIDTH-bit add/subtract: one cla_4bit time-multiplexed over
// WIDTH/4 cycles, with the inter-nibble carry held in a register.
module alu_nibble_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_nibble_addsub_if.slave    bus,
  output state_t                dbg_state
);
  localparam int NIB = nib_count(WIDTH);
  localparam int KW  = idx_width(WIDTH);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("alu_nibble_addsub: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t           state;
  state_t           state_n;
  logic [KW-1:0]    k;
  logic             c;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_n;
  logic             carry_q;
  logic             overflow_q;
  logic             zero_q;
  logic             done_q;

  logic [KW+1:0]    bit_idx;
  logic [3:0]       nib_s;
  logic             nib_g;
  logic             nib_p;
  logic             c_next;
  logic             last;
  logic             accept;

  assign bit_idx = {k, 2'b00};
  assign last    = (k == KW'(NIB - 1));
  assign accept  = (state == IDLE) && bus.start;
  assign c_next  = nib_g | (nib_p & c);

  cla_4bit u_cla (
    .a    (a_q[bit_idx +: 4]),
    .b    (b_q[bit_idx +: 4]),
    .cin  (c),
    .s    (nib_s),
    .gout (nib_g),
    .pout (nib_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    result_n = result_q;
    result_n[bit_idx +: 4] = nib_s;
    case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (last)      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k          <= '0;
      c          <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        // Subtract as A + ~B + 1: the +1 enters as the initial carry.
        a_q      <= bus.a;
        b_q      <= bus.sub ? ~bus.b : bus.b;
        c        <= bus.sub;
        k        <= '0;
        result_q <= '0;
      end else if (state == RUN) begin
        result_q <= result_n;
        c        <= c_next;
        k        <= last ? '0 : k + 1'b1;
        if (last) begin
          done_q     <= 1'b1;
          carry_q    <= c_next;
          overflow_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[3] != a_q[WIDTH-1]);
          zero_q     <= (result_n == '0);
        end
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;
  assign dbg_state    = state;
endmodule

// File: tb/tb_alu_nibble_addsub.sv
// Directed bench for alu_nibble_addsub: hand-computed vectors go into an
// expected queue, and a monitor compares every done pulse against it.
module tb_alu_nibble_addsub;
  import alu_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 8;
  localparam int EW  = W + 3;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     cyc;
  int     n_chk;
  int     n_fail;

  logic [EW-1:0] exp_q[$];
  int            cyc_q[$];

  alu_nibble_addsub_if #(.WIDTH(W)) bus ();

  alu_nibble_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [W-1:0] r, input logic cy,
                                         input logic ov, input logic z);
    return {r, cy, ov, z};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            ec;
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with nothing pending (cycle %0d)", cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        check("result",   64'(bus.result),   64'(e[EW-1:3]));
        check("carry",    64'(bus.carry),    64'(e[2]));
        check("overflow", 64'(bus.overflow), 64'(e[1]));
        check("zero",     64'(bus.zero),     64'(e[0]));
        check("latency",  64'(cyc),          64'(ec));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check("wait_idle_timeout", 64'(bus.busy), 64'(0));
  endtask

  // Issue one request from idle; returns just after the accepting edge.
  task automatic start_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [EW-1:0] exp, input bit hold);
    wait_idle();
    bus.start = 1'b1;
    bus.sub   = s;
    bus.a     = av;
    bus.b     = bv;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    cyc_q.push_back(cyc + LAT);
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    n_chk     = 0;
    n_fail    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",     64'(bus.busy),     64'(0));
    check("rst_done",     64'(bus.done),     64'(0));
    check("rst_result",   64'(bus.result),   64'(0));
    check("rst_flags",    64'({bus.carry, bus.overflow, bus.zero}), 64'(0));
    check("rst_state",    64'(dbg_state),    64'(0));
    rst_n = 1'b1;

    // Wrap to zero, with busy profile over the whole operation.
    start_op(1'b0, 32'h0000_0001, 32'hFFFF_FFFF, pack(32'h0000_0000, 1'b1, 1'b0, 1'b1), 1'b0);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      check("busy_during_op", 64'(bus.busy), 64'(1));
      check("no_early_done",  64'(bus.done), 64'(0));
    end
    @(negedge clk);
    check("busy_after_op", 64'(bus.busy), 64'(0));
    check("done_at_lat",   64'(bus.done), 64'(1));
    drain();

    start_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, pack(32'h8000_0000, 1'b0, 1'b1, 1'b0), 1'b0);
    start_op(1'b1, 32'h8000_0000, 32'h0000_0001, pack(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0), 1'b0);
    start_op(1'b1, 32'h0000_0003, 32'h0000_0005, pack(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0), 1'b0);
    start_op(1'b1, 32'hDEAD_BEEF, 32'h0000_0000, pack(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0), 1'b0);
    start_op(1'b1, 32'h0000_0005, 32'h0000_0005, pack(32'h0000_0000, 1'b1, 1'b0, 1'b1), 1'b0);
    drain();

    // Start pulsed mid-operation must be ignored.
    start_op(1'b0, 32'h0F0F_0F0F, 32'h0101_0101, pack(32'h1010_1010, 1'b0, 1'b0, 1'b0), 1'b0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = 1'b1;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'h0000_0001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain();
    repeat (4) @(negedge clk);

    // Reset mid-operation: outputs clear at once and no done follows.
    start_op(1'b0, 32'h1111_1111, 32'h2222_2222, pack(32'h3333_3333, 1'b0, 1'b0, 1'b0), 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy",   64'(bus.busy),   64'(0));
    check("abort_done",   64'(bus.done),   64'(0));
    check("abort_result", 64'(bus.result), 64'(0));
    check("abort_flags",  64'({bus.carry, bus.overflow, bus.zero}), 64'(0));
    void'(exp_q.pop_back());
    void'(cyc_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    start_op(1'b0, 32'h0000_0010, 32'h0000_0020, pack(32'h0000_0030, 1'b0, 1'b0, 1'b0), 1'b0);
    drain();

    // Start held through the done cycle: second op accepted back-to-back.
    start_op(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, pack(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0), 1'b1);
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) check("b2b_done_timeout", 64'(bus.done), 64'(1));
    bus.a = 32'h1234_5678;
    bus.b = 32'h1111_1111;
    exp_q.push_back(pack(32'h2345_6789, 1'b0, 1'b0, 1'b0));
    cyc_q.push_back(cyc + 1 + LAT);
    @(posedge clk);
    #1;
    check("b2b_accept_busy", 64'(bus.busy), 64'(1));
    check("b2b_done_drop",   64'(bus.done), 64'(0));
    bus.start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
